// File: rtl/alu_mem_resp_if.sv
// Request/response bundle between the ALU load/store outputs and the
// data-memory responder.
interface alu_mem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic        load;
    logic        store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    modport master (
        output req_valid, load, store, addr, wdata, rsp_ready,
        input  req_ready, rsp_valid, rdata, err, busy
    );

    modport slave (
        input  req_valid, load, store, addr, wdata, rsp_ready,
        output req_ready, rsp_valid, rdata, err, busy
    );
endinterface

// File: rtl/alu_mem_resp.sv
// Data-memory responder: serialised load/store against a word RAM with a
// programmable wait and a back-pressurable response channel.
module alu_mem_resp #(
    parameter int AW_WORDS = 8,
    parameter int LAT      = 2
) (
    input logic           clk,
    input logic           rst_n,
    alu_mem_resp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'((LAT == 0) ? 0 : LAT - 1);

    state_t              state, state_nx;
    logic [3:0]          cnt, cnt_nx;
    logic [31:0]         addr_q, wdata_q;
    logic                load_q, store_q;
    logic [31:0]         rdata_q;
    logic                err_q;
    logic                access;
    logic                in_idle;
    logic [31:0]         a_sel, d_sel;
    logic                ld_sel, st_sel;
    logic                bad;
    logic [AW_WORDS-1:0] idx;
    logic [31:0]         ram [2**AW_WORDS];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        access   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (LAT == 0) begin
                        state_nx = RESP;
                        access   = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = RESP;
                    access   = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // With LAT==0 the access happens on the accept edge, before capture.
    assign in_idle = (state == IDLE);
    assign a_sel   = in_idle ? bus.addr  : addr_q;
    assign d_sel   = in_idle ? bus.wdata : wdata_q;
    assign ld_sel  = in_idle ? bus.load  : load_q;
    assign st_sel  = in_idle ? bus.store : store_q;

    assign bad = (ld_sel == st_sel)
               | (a_sel[1:0] != 2'b00)
               | ((a_sel >> (AW_WORDS + 2)) != 32'd0);
    assign idx = a_sel[AW_WORDS+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (in_idle && bus.req_valid) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                load_q  <= bus.load;
                store_q <= bus.store;
            end
            if (access) begin
                err_q   <= bad;
                rdata_q <= (!bad && ld_sel) ? ram[idx] : 32'd0;
            end
        end
    end

    // RAM holds its contents across reset; a write needs reset released.
    always_ff @(posedge clk) begin
        if (access && rst_n && !bad && st_sel) ram[idx] <= d_sel;
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
endmodule

// File: doc/alu_mem_resp.md
# alu_mem_resp

Data-memory responder at the far end of the ALU's load/store outputs. It accepts one load or store request per handshake: the byte address comes from the ALU result `c`, the store data from `gr2`. It services the request against an internal word-addressed RAM after a programmable wait, then returns read data or an error through a valid/ready response channel. It sits between the execute stage and writeback, and turns the ALU's combinational `load`/`store` strobes into a sequential, back-pressurable memory transaction.

## Interface
- `AW_WORDS`, default 8: log2 of RAM depth in 32-bit words (256 words).
- `LAT`, default 2: wait cycles between request accept and response, legal range 0..15.

Ports:
- `clk`, in, 1: single clock. All state updates on its rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: responder can accept a request.
- `load`, in, 1: request is a load (ALU `load`).
- `store`, in, 1: request is a store (ALU `store`).
- `addr`, in, 32: byte address (ALU `c`).
- `wdata`, in, 32: store data (`gr2`).
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rdata`, out, 32: load data; 0 for stores and errors.
- `err`, out, 1: request was rejected.
- `busy`, out, 1: a transaction is in flight (state is not IDLE).

## Operation
- FSM states: IDLE, WAIT, RESP. Reset puts the FSM in IDLE.
- `req_ready` = (state==IDLE). `busy` = (state!=IDLE). `rsp_valid` = (state==RESP).
- **Accept:** `req_valid && req_ready` at a rising edge. On accept, capture `addr`, `wdata`, `load`, `store` into internal registers; the inputs are don't-care afterwards.
- **Accept transitions:**
  - LAT>0: go to WAIT and load the counter with LAT-1.
  - LAT==0: go straight to RESP and perform the access on that same edge.
- **WAIT:** each edge with cnt!=0 decrements cnt. An edge with cnt==0 goes to RESP and performs the access on that edge.
- **Error conditions.** Any of the following sets `err`=1, forces `rdata`=0, and makes no RAM write:
  - `load` and `store` both 1;
  - `load` and `store` both 0;
  - addr[1:0]!=0 (misaligned);
  - addr[31:AW_WORDS+2]!=0 (out of range).
- **Access, no error:**
  - Word index is addr[AW_WORDS+1:2].
  - Load: `rdata` = RAM[index], `err`=0.
  - Store: RAM[index] = `wdata`, `rdata`=0, `err`=0.
- **RESP:** `rdata` and `err` are held stable while `rsp_ready`=0. An edge with `rsp_ready`=1 returns the FSM to IDLE. A new request cannot be accepted on the same edge that retires the response.
- **RAM:** contents are not cleared by reset; initial contents are undefined.
- **Counter:** 4-bit. No arithmetic on data; addresses are used unsigned.

## Timing
- **Reset values:** `req_ready`=1, `rsp_valid`=0, `busy`=0, `rdata`=0, `err`=0, cnt=0.
- **Latency:** for accept at edge E, `rsp_valid` rises after edge E+LAT. With LAT=0 it is high in the cycle immediately following the accept.
- **Throughput:** at most one transaction per LAT+2 cycles when `rsp_ready` is held at 1.
- **Write timing:** the RAM write happens only at the WAIT→RESP (or IDLE→RESP when LAT==0) edge.
  - Reset asserted before that edge: the store is abandoned and RAM is unchanged.
  - Reset asserted after that edge: the write persists.
- **Reset mid-operation:** async assertion immediately forces IDLE and the reset output values; any pending response is lost.
- **Load-after-store:** a load accepted after a store's response retires returns the stored value. No forwarding is needed because transactions are strictly serialized.
- `req_valid` while `req_ready`=0 is simply not accepted; there is no buffering.

## Test plan
- **Store then load:** LAT=2. Store addr=0x10, wdata=0xDEADBEEF, then load addr=0x10.
  - `rsp_valid` rises 2 edges after each accept.
  - Store response: `err`=0, `rdata`=0.
  - Load response: `rdata`=0xDEADBEEF.
- **Misaligned:** load addr=0x13 → `err`=1, `rdata`=0. A subsequent load of 0x10 still returns its prior value.
- **Out of range:** store addr=0x400 with AW_WORDS=8 → `err`=1, no RAM change. Then store both-strobes and no-strobe requests → each returns `err`=1.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles in RESP.
  - `rdata`, `err` and `rsp_valid` stay stable; `req_ready`=0 and `req_valid` is ignored.
  - After `rsp_ready`=1 the FSM returns to IDLE, and `req_ready`=1 the next cycle.
- **Reset mid-WAIT:** store 0x55 to 0x20, where 0x20 previously held 0x11. Pulse `rst_n` low during WAIT.
  - Outputs go to reset values immediately.
  - A later load of 0x20 returns 0x11.
- **LAT=0:** store then load 0x8; `rsp_valid` is high the cycle after each accept, and the load returns the stored data.
